// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU share arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_arb_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Request classes carried on reqN_aluop.
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;
    localparam logic [1:0] ALUOP_RSV = 2'b11;

    // ALU control codes produced by the decoder.
    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b1000;
    localparam logic [3:0] CTRL_SLT  = 4'b0010;
    localparam logic [3:0] CTRL_SLTU = 4'b0011;
    localparam logic [3:0] CTRL_NOP  = 4'b1010;

    // Instruction fields of one request, bundled for the grant mux.
    typedef struct packed {
        logic [1:0] aluop;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } op_fields_t;

endpackage

// File: rtl/alu_op_decode.sv
// Maps (aluop, funct3, funct7) of a request onto the shared ALU control code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; always produces a code.
//
// Ports: aluop/funct3/funct7 in, ctrl (4 bits) out.
module alu_op_decode
    import alu_arb_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] ctrl
);

    // Only funct7[5] selects sub/sra; the remaining bits are don't-care here.
    logic unused_funct7_bits;
    assign unused_funct7_bits = ^{funct7[6], funct7[4:0]};

    always_comb begin
        ctrl = CTRL_NOP;
        case (aluop)
            ALUOP_MEM: ctrl = CTRL_ADD;
            ALUOP_BR: begin
                case (funct3)
                    3'b000, 3'b001: ctrl = CTRL_SUB;
                    3'b100, 3'b101: ctrl = CTRL_SLT;
                    3'b110, 3'b111: ctrl = CTRL_SLTU;
                    default:        ctrl = CTRL_NOP;
                endcase
            end
            ALUOP_RI:  ctrl = {funct7[5], funct3};
            default:   ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; one transaction in flight.
// Latency: grant edge + 2 cycles to rsp_valid; at least 3 cycles per transaction.
// Backpressure: rsp_ready=0 holds the response indefinitely; no request is accepted meanwhile.
//
// Ports: clk/rst_n (sync, active-low); req0_*/req1_* valid/ready requests with aluop,
// funct3, funct7, a, b; alu_ctrl/alu_a/alu_b to the shared ALU, alu_res/alu_zero back;
// rsp_valid/rsp_ready handshake carrying rsp_id, rsp_data, rsp_zero.
// Build option: define ALU_ARB_RR_EN for round-robin between the two requesters;
// otherwise req0 has fixed priority and no pointer register exists.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_aluop,
    input  logic [2:0]      req0_funct3,
    input  logic [6:0]      req0_funct7,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_aluop,
    input  logic [2:0]      req1_funct3,
    input  logic [6:0]      req1_funct7,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,

    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_zero,

    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_zero,
    input  logic            rsp_ready
);

    state_t          state_q, state_d;
    logic            id_q, id_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_zero_q, rsp_zero_d;
`ifdef ALU_ARB_RR_EN
    logic            ptr_q, ptr_d;
`endif

    logic            gnt0, gnt1, gnt_any;
    op_fields_t      sel_op;
    logic [3:0]      dec_ctrl;

    // Grants are combinational from valid and only offered in IDLE. Gating with
    // rst_n keeps both readies low while reset is being applied.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && rst_n) begin
`ifdef ALU_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                gnt0 = ~ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
`else
            gnt0 = req0_valid;
            gnt1 = req1_valid & ~req0_valid;
`endif
        end
    end

    assign gnt_any    = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Single decoder, fed from whichever side is being granted.
    assign sel_op = gnt1 ? {req1_aluop, req1_funct3, req1_funct7}
                         : {req0_aluop, req0_funct3, req0_funct7};

    alu_op_decode u_dec (
        .aluop  (sel_op.aluop),
        .funct3 (sel_op.funct3),
        .funct7 (sel_op.funct7),
        .ctrl   (dec_ctrl)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        ctrl_d     = ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
`ifdef ALU_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    id_d    = gnt1;
                    ctrl_d  = dec_ctrl;
                    a_d     = gnt1 ? req1_a : req0_a;
                    b_d     = gnt1 ? req1_b : req0_b;
                    state_d = ISSUE;
`ifdef ALU_ARB_RR_EN
                    // Point at the side that lost (or was absent), so a side
                    // can never win twice while the other keeps asking.
                    ptr_d   = ~gnt1;
`endif
                end
            end
            ISSUE: begin
                rsp_data_d = alu_res;
                rsp_zero_d = alu_zero;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            id_q       <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            ctrl_q     <= ctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
`ifdef ALU_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // The ALU only sees real operands during ISSUE; otherwise a quiet NOP.
    assign alu_ctrl  = (state_q == ISSUE) ? ctrl_q : CTRL_NOP;
    assign alu_a     = (state_q == ISSUE) ? a_q    : '0;
    assign alu_b     = (state_q == ISSUE) ? b_q    : '0;

    // Response is suppressed while reset is asserted so a discarded
    // transaction can never be consumed.
    assign rsp_valid = (state_q == RESP) && rst_n;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req0_ready;
    logic [1:0]      req0_aluop;
    logic [2:0]      req0_funct3;
    logic [6:0]      req0_funct7;
    logic [XLEN-1:0] req0_a, req0_b;
    logic            req1_valid, req1_ready;
    logic [1:0]      req1_aluop;
    logic [2:0]      req1_funct3;
    logic [6:0]      req1_funct7;
    logic [XLEN-1:0] req1_a, req1_b;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    logic            alu_zero;
    logic            rsp_valid, rsp_id, rsp_zero, rsp_ready;
    logic [XLEN-1:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
        .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
        .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .rsp_ready(rsp_ready)
    );

    // Behavioural ALU attached to the shared port.
    function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] c, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        case (c)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_res  = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_zero = (alu_res == 32'd0);
    end

    // Reference control-code table: branches group funct3 in pairs.
    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7);
        if (op == 2'b10) return {f7[5], f3};
        if (op == 2'b00) return 4'b0000;
        if (op == 2'b01) begin
            case (f3[2:1])
                2'b00:   return 4'b1000;
                2'b10:   return 4'b0010;
                2'b11:   return 4'b0011;
                default: return 4'b1010;
            endcase
        end
        return 4'b1010;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Transaction-level model and per-cycle compare ----------------
    // m_age: -1 = nothing in flight, 1 = on the ALU this cycle, 2 = response held.
    int              m_age = -1;
    bit              m_ptr = 1'b0;
    bit              m_id;
    logic [3:0]      m_ctrl;
    logic [XLEN-1:0] m_a, m_b, m_data;
    bit              m_zero;
    bit              e_r0, e_r1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready0", 64'(req0_ready), 64'd0);
            chk("rst_ready1", 64'(req1_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            m_age = -1;
            m_ptr = 1'b0;
        end else begin
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (m_age < 0) begin
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
                    if (m_ptr) e_r1 = 1'b1; else e_r0 = 1'b1;
`else
                    e_r0 = 1'b1;
`endif
                end else begin
                    e_r0 = req0_valid;
                    e_r1 = req1_valid;
                end
            end
            chk("m_ready0", 64'(req0_ready), 64'(e_r0));
            chk("m_ready1", 64'(req1_ready), 64'(e_r1));
            if (m_age == 1) begin
                chk("m_alu_ctrl", 64'(alu_ctrl), 64'(m_ctrl));
                chk("m_alu_a", 64'(alu_a), 64'(m_a));
                chk("m_alu_b", 64'(alu_b), 64'(m_b));
            end else begin
                chk("m_alu_ctrl_idle", 64'(alu_ctrl), 64'd10);
                chk("m_alu_a_idle", 64'(alu_a), 64'd0);
                chk("m_alu_b_idle", 64'(alu_b), 64'd0);
            end
            chk("m_rsp_valid", 64'(rsp_valid), 64'(m_age >= 2));
            if (m_age >= 2) begin
                chk("m_rsp_id", 64'(rsp_id), 64'(m_id));
                chk("m_rsp_data", 64'(rsp_data), 64'(m_data));
                chk("m_rsp_zero", 64'(rsp_zero), 64'(m_zero));
            end
            // Advance the model across the coming rising edge.
            if (m_age < 0) begin
                if (e_r0 || e_r1) begin
                    m_id   = e_r1;
                    m_ctrl = e_r1 ? ref_decode(req1_aluop, req1_funct3, req1_funct7)
                                  : ref_decode(req0_aluop, req0_funct3, req0_funct7);
                    m_a    = e_r1 ? req1_a : req0_a;
                    m_b    = e_r1 ? req1_b : req0_b;
                    m_ptr  = ~e_r1;
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                m_data = alu_fn(m_ctrl, m_a, m_b);
                m_zero = (m_data == 32'd0);
                m_age  = 2;
            end else if (rsp_ready) begin
                m_age = -1;
            end
        end
    end

    // ---------------- Directed stimulus with literal expectations ----------------
    task automatic set_req(input bit id, input bit v, input logic [1:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (id) begin
            req1_valid = v; req1_aluop = op; req1_funct3 = f3; req1_funct7 = f7;
            req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_aluop = op; req0_funct3 = f3; req0_funct7 = f7;
            req0_a = a; req0_b = b;
        end
    endtask

    // Waits (bounded) for requester id to be granted; returns just after the grant edge.
    task automatic wait_grant(input bit id);
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) ok = 1'b1;
        end
        chk("grant_seen", 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_txn(input string name, input bit id, input logic [1:0] op,
                          input logic [2:0] f3, input logic [6:0] f7,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [3:0] exp_ctrl, input logic [XLEN-1:0] exp_data);
        set_req(id, 1'b1, op, f3, f7, a, b);
        wait_grant(id);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        @(negedge clk);
        chk({name, "_ctrl"}, 64'(alu_ctrl), 64'(exp_ctrl));
        chk({name, "_early_valid"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk({name, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({name, "_id"}, 64'(rsp_id), 64'(id));
        chk({name, "_data"}, 64'(rsp_data), 64'(exp_data));
        @(posedge clk); #1;
    endtask

    bit got_order[4];
    bit exp_order[4];

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 2'b00, 3'b000, 7'd0, 32'd0, 32'd0);  // valid during reset
        set_req(1'b1, 1'b0, 2'b00, 3'b000, 7'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready0", 64'(req0_ready), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_zero", 64'(rsp_zero), 64'd0);
        chk("reset_alu_ctrl", 64'(alu_ctrl), 64'hA);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        @(posedge clk); #1;

        // Subtract from req0: 5 - 3.
        do_txn("sub", 1'b0, 2'b10, 3'b000, 7'b0100000, 32'd5, 32'd3, 4'b1000, 32'd2);
        // Branch decode on req1.
        do_txn("beq", 1'b1, 2'b01, 3'b000, 7'd0, 32'd7, 32'd7, 4'b1000, 32'd0);
        do_txn("bge", 1'b1, 2'b01, 3'b101, 7'd0, 32'd3, 32'd9, 4'b0010, 32'd1);
        do_txn("bgeu", 1'b1, 2'b01, 3'b111, 7'd0, 32'd9, 32'd3, 4'b0011, 32'd0);
        do_txn("br011", 1'b1, 2'b01, 3'b011, 7'd0, 32'd9, 32'd3, 4'b1010, 32'd0);
        // Load address add.
        do_txn("load", 1'b0, 2'b00, 3'b010, 7'd0, 32'h1000, 32'h10, 4'b0000, 32'h1010);
        // R-type AND and reserved class.
        do_txn("and", 1'b1, 2'b10, 3'b111, 7'd0, 32'hF0F0, 32'hFF00, 4'b0111, 32'hF000);
        do_txn("rsv", 1'b0, 2'b11, 3'b101, 7'b0100000, 32'd4, 32'd4, 4'b1010, 32'd0);

        // Response stall with both requesters pushing.
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 2'b10, 3'b000, 7'd0, 32'd10, 32'd20);
        wait_grant(1'b0);
        set_req(1'b1, 1'b1, 2'b10, 3'b000, 7'd0, 32'd1, 32'd1);
        @(negedge clk);  // ISSUE
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_data", 64'(rsp_data), 64'd30);
            chk("stall_id", 64'(rsp_id), 64'd0);
            chk("stall_ready0", 64'(req0_ready), 64'd0);
            chk("stall_ready1", 64'(req1_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_back_idle", 64'(rsp_valid), 64'd0);
        chk("stall_one_grant", 64'(req0_ready ^ req1_ready), 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset while the transaction is on the ALU.
        set_req(1'b1, 1'b1, 2'b10, 3'b000, 7'd0, 32'd8, 32'd9);
        wait_grant(1'b1);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_issue_valid", 64'(rsp_valid), 64'd0);
        chk("rst_issue_data", 64'(rsp_data), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Both requesters continuously valid for four transactions.
`ifdef ALU_ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        set_req(1'b0, 1'b1, 2'b10, 3'b000, 7'd0, 32'd100, 32'd1);
        set_req(1'b1, 1'b1, 2'b10, 3'b000, 7'd0, 32'd200, 32'd2);
        for (int k = 0; k < 4; k++) begin
            bit ok = 1'b0;
            for (int n = 0; n < 20 && !ok; n++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    ok = 1'b1;
                    got_order[k] = req1_ready;
                end
            end
            chk("order_grant_seen", 64'(ok), 64'd1);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) chk($sformatf("order_%0d", k), 64'(got_order[k]), 64'(exp_order[k]));
        repeat (4) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) holds a valid ALU request.
REQ-006 reqN_ready  output  1  request N accepted this cycle when reqN_valid=1.
REQ-007 reqN_aluop  input  2  request class: 00 load/store/jalr, 01 branch, 10 R/I-type, 11 reserved.
REQ-008 reqN_funct3 / reqN_funct7  input  3 / 7  instruction fields of request N.
REQ-009 reqN_a / reqN_b  input  XLEN  operands of request N.
REQ-010 alu_ctrl  output  4  control code to the shared ALU.
REQ-011 alu_a / alu_b  output  XLEN  operands to the shared ALU.
REQ-012 alu_res / alu_zero  input  XLEN / 1  shared ALU combinational result and zero flag.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_id  output  1  index of the requester that owns the response.
REQ-015 rsp_data / rsp_zero  output  XLEN / 1  captured ALU result and zero flag.
REQ-016 rsp_ready  input  1  consumer accepts the response.

Function
REQ-017 SHALL use FSM states IDLE, ISSUE and RESP.
REQ-018 In IDLE, SHALL grant at most one request per cycle: reqN_ready=1 only for the granted N, combinationally from reqN_valid; no ready is asserted in ISSUE or RESP.
REQ-019 On a grant, SHALL capture the granted id, ctrl code and operands, then go to ISSUE.
REQ-020 In ISSUE, SHALL drive alu_ctrl/alu_a/alu_b from the captured registers, capture alu_res/alu_zero at the clock edge, and go to RESP.
REQ-021 In RESP, SHALL hold rsp_valid=1 with stable rsp_id/data/zero until rsp_ready=1, then go to IDLE; rsp_ready=0 stalls indefinitely.
REQ-022 Latency is grant edge +2 cycles to rsp_valid; minimum period is 3 cycles per transaction.
REQ-023 Outside ISSUE, SHALL drive alu_a=alu_b=0 and alu_ctrl=4'b1010.
REQ-024 Ctrl decode for aluop=10 SHALL be {funct7[5],funct3}.
REQ-025 Ctrl decode for aluop=00 SHALL be 0000.
REQ-026 Ctrl decode for aluop=01 SHALL be: funct3 000/001 -> 1000, 100/101 -> 0010, 110/111 -> 0011, 010/011 -> 1010.
REQ-027 Ctrl decode for aluop=11 SHALL be 1010; decode SHALL be fully specified, with no latches.
REQ-028 When both requests are valid in IDLE, SHALL grant the side indicated by the priority pointer; the pointer flips to the other side after every grant.
REQ-029 When a single request is valid, SHALL grant it regardless of the pointer and flip the pointer.
REQ-030 A requester SHALL NOT be granted twice in a row while the other is continuously valid.

Reset
REQ-031 When rst_n=0, SHALL set state=IDLE, pointer=0, and rsp_valid=rsp_id=rsp_data=rsp_zero=0; all reqN_ready=0 during reset.
REQ-032 Reset in ISSUE or RESP SHALL discard the in-flight transaction; no response is produced after reset.

Configuration
REQ-033 Macro ALU_ARB_RR_EN: when defined, arbitration SHALL follow REQ-028..REQ-030.
REQ-034 When ALU_ARB_RR_EN is undefined, SHALL use fixed priority with req0 always winning, and the pointer register SHALL be removed.

Structure
REQ-035 Package alu_arb_pkg SHALL hold the XLEN default, the state enum (IDLE/ISSUE/RESP), and the ctrl-code constants 0000, 1000, 0010, 0011, 1010.
REQ-036 The ctrl decode SHALL be a combinational sub-module alu_op_decode (aluop, funct3, funct7 -> ctrl), instantiated once on the granted request.

Verification
REQ-037 req0 alone, aluop=10, f7=0100000, f3=000, a=5, b=3, ALU model subtract -> alu_ctrl=1000 in ISSUE; rsp_valid two cycles after grant; rsp_id=0; rsp_data=2.
REQ-038 Both valid each cycle for 4 transactions, RR enabled -> grant order 0,1,0,1; without ALU_ARB_RR_EN -> 0,0,0,0.
REQ-039 Branch request with aluop=01 and f3 = 000, 101, 111, 011 -> alu_ctrl = 1000, 0010, 0011, 1010 respectively.
REQ-040 rsp_ready held 0 for 5 cycles in RESP -> rsp fields stable, both reqN_ready=0; accepted on the first cycle rsp_ready=1, then IDLE.
REQ-041 rst_n=0 asserted in ISSUE -> next cycle IDLE with rsp_valid=0; no response for that request ever appears.
REQ-042 aluop=00 load request with a=0x1000, b=0x10 -> alu_ctrl=0000; rsp_data=0x1010 with an ADD model.
